ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Round-robin arbiter that shares the single RAM port among NREQ cache requesters (default: icache/dcache of 2 CPUs).
- Sits between the caches' miss/writeback request lines and the RAM model, in front of the coherence controller's RAM side.
- Supports 1-word and 2-word burst transactions. Grant is held for the whole burst.
- Reports RAM ERROR state and watchdog timeouts.

Parameters:
- NREQ, 4, number of requesters (power of 2, ≥2).
- TIMEOUT, 64, max cycles a grant may wait for one RAM ACCESS before abort.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous and active-high.
- req_ren  in  NREQ  per-requester read request.
- req_wen  in  NREQ  per-requester write request.
- req_burst  in  NREQ  1 = 2-word transaction, 0 = single word.
- req_addr  in  NREQx32  per-requester word address.
- req_store  in  NREQx32  per-requester write data.
- req_wait  out  NREQ  1 = stall; 0 for exactly the cycle a beat completes.
- req_load  out  32  read data, broadcast; valid when the owner's req_wait=0.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t {FREE, BUSY, ACCESS, ERROR}.
- grant_id  out  log2(NREQ)  current owner; valid when busy=1.
- busy  out  1  a grant is active.
- err  out  1  one-cycle pulse on ERROR or timeout.
- err_id  out  log2(NREQ)  requester aborted by the err pulse; held until the next err.

Behaviour:
- Reset values (RST=1 at posedge):
  - state=IDLE, rr_ptr=0, beat=0, wdog=0.
  - Outputs: req_wait all 1, ramREN=ramWEN=0, ramaddr=ramstore=0, busy=0, grant_id=0, err=0, err_id=0.
  - Applies mid-transaction too: the grant is dropped at once and no beat completes.
- States:
  - IDLE: requester i is active if req_ren[i]|req_wen[i]. Pick the first active index scanning rr_ptr, rr_ptr+1, … mod NREQ. Register it as grant_id, set beat=0, wdog=0, go to GRANT. Nothing active: stay in IDLE.
  - GRANT: drive ramaddr/ramstore from the owner's addr/store. ramWEN=req_wen[g]. ramREN=req_ren[g]&~req_wen[g], so write wins if both are set.
    - wdog increments each cycle ramstate≠ACCESS.
    - ramstate==ACCESS: req_wait[g]=0 for that cycle (combinational) and req_load=ramload. wdog clears.
      - If req_burst[g] and beat==0: beat←1, stay in GRANT. The requester updates addr/store in the next cycle.
      - Otherwise: go to IDLE with rr_ptr←g+1 mod NREQ.
    - ramstate==ERROR, or wdog reaches TIMEOUT-1 without ACCESS: err=1 next cycle, err_id=g, go to IDLE, rr_ptr←g+1. req_wait[g] stays 1.
    - Owner drops both ren and wen before completion: deassert ram enables that cycle, go to IDLE, rr_ptr←g+1, no err.
- Latency:
  - Request in IDLE → ram enables asserted the next cycle.
  - Minimum 2 cycles from request to the first req_wait=0.
  - 1 idle cycle between consecutive grants, which gives fairness and a clean bus.
- Non-owners always see req_wait=1. req_burst is sampled per beat from the owner.
- Fairness: a requester that stays active is granted within NREQ-1 other transactions.
- busy=1 exactly while in GRANT.

Decomposition:
- Add to cpu_types_pkg:
  - ramstate_t, reused.
  - arb_state_t {IDLE, GRANT}.
  - word_t.
- One sub-module, rr_picker: combinational.
  - Inputs: active mask, rr_ptr.
  - Outputs: found, index.
  - Also reusable by the coherence controller's bus arbitration.

Test Plan:
- Single read: req_ren[2]=1, addr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF → ramREN=1, ramaddr=0x40; req_wait[2]=0 with req_load=0xDEADBEEF on the 4th cycle after the request; rr_ptr=3.
- Contention: all four requesters request at once from reset → grant order 0,1,2,3. Each grant is separated by one IDLE cycle. No req_wait[i]=0 for non-owners.
- Burst write: req_wen[1]=1, req_burst[1]=1, addr 0x100 then 0x104, store 0xA then 0xB → two ACCESS beats with ramWEN=1, ramstore matching each address, grant held (busy=1) across both beats.
- Error/timeout:
  - ramstate=ERROR during the grant to 3 → err pulse, err_id=3, req_wait[3] stays 1, next grant goes to 0.
  - ramstate held BUSY for 64 cycles → err at TIMEOUT.
- Withdraw/reset: requester 0 drops ren mid-GRANT → enables drop, no err, next active requester granted. RST asserted mid-burst → all outputs at reset values on the next edge.
- Both ren and wen set on requester 2 → ramWEN=1, ramREN=0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM port arbiter: RAM handshake states, arbiter FSM
// states and the machine word.
package ram_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the requester-side and RAM-side signals around the arbiter.
// slave is the arbiter's view; master is the view of the caches plus RAM model.
interface ram_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import ram_arbiter_pkg::*;

    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_ren;
    logic [NREQ-1:0]   req_wen;
    logic [NREQ-1:0]   req_burst;
    word_t [NREQ-1:0]  req_addr;
    word_t [NREQ-1:0]  req_store;
    logic [NREQ-1:0]   req_wait;
    word_t             req_load;

    word_t             ramaddr;
    word_t             ramstore;
    logic              ramREN;
    logic              ramWEN;
    word_t             ramload;
    ramstate_t         ramstate;

    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              err;
    logic [IW-1:0]     err_id;

    modport slave (
        input  req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, ramaddr, ramstore, ramREN, ramWEN,
               grant_id, busy, err, err_id
    );

    modport master (
        output req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, ramaddr, ramstore, ramREN, ramWEN,
               grant_id, busy, err, err_id
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Round-robin picker: first set bit of active_i scanning ptr_i, ptr_i+1, ...
// modulo NREQ. Purely combinational so other bus arbiters can reuse it.
module ram_arbiter_rr_picker #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] active_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            found_o,
    output logic [IW-1:0]   index_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        found_o = 1'b0;
        index_o = ptr_i;
        // Walk from the farthest offset down so the nearest active one wins.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            logic [IW-1:0] cand;
            cand = ptr_i + IW'(k);
            if (active_i[cand]) begin
                found_o = 1'b1;
                index_o = cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single RAM port shared by NREQ cache requesters.
// Holds the grant across 1- or 2-word bursts and flags RAM errors/timeouts.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic          CLK,
    input logic          RST,
    ram_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned WW = $clog2(TIMEOUT);

    arb_state_t     state_q;
    logic [IW-1:0]  grant_q;
    logic [IW-1:0]  rr_ptr_q;
    logic           beat_q;
    logic [WW-1:0]  wdog_q;
    logic           err_q;
    logic [IW-1:0]  err_id_q;

    logic [NREQ-1:0] active_d;
    logic            pick_found_d;
    logic [IW-1:0]   pick_idx_d;

    logic            owner_ren_d;
    logic            owner_wen_d;
    logic            owner_active_d;
    logic            live_d;
    logic            beat_done_d;
    logic            abort_d;
    logic [IW-1:0]   next_ptr_d;

    assign active_d = bus.req_ren | bus.req_wen;

    ram_arbiter_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .active_i (active_d),
        .ptr_i    (rr_ptr_q),
        .found_o  (pick_found_d),
        .index_o  (pick_idx_d)
    );

    // Decode of the current owner's request against the RAM handshake.
    always_comb begin
        owner_ren_d    = bus.req_ren[grant_q];
        owner_wen_d    = bus.req_wen[grant_q];
        owner_active_d = owner_ren_d | owner_wen_d;
        live_d         = (state_q == GRANT) && owner_active_d && !RST;
        beat_done_d    = live_d && (bus.ramstate == ACCESS);
        abort_d        = live_d && !beat_done_d &&
                         ((bus.ramstate == ERROR) || (wdog_q == WW'(TIMEOUT - 1)));
        next_ptr_d     = grant_q + IW'(1);
    end

    // RAM port and requester handshake follow the owner combinationally.
    always_comb begin
        bus.req_wait = '1;
        bus.req_load = '0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        if (live_d) begin
            bus.ramaddr  = bus.req_addr[grant_q];
            bus.ramstore = bus.req_store[grant_q];
            bus.ramWEN   = owner_wen_d;
            bus.ramREN   = owner_ren_d & ~owner_wen_d;
        end
        if (beat_done_d) begin
            bus.req_wait[grant_q] = 1'b0;
            bus.req_load          = bus.ramload;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= 1'b0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        grant_q <= pick_idx_d;
                        beat_q  <= 1'b0;
                        wdog_q  <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_active_d) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr_d;
                    end else if (beat_done_d) begin
                        wdog_q <= '0;
                        if (bus.req_burst[grant_q] && !beat_q) begin
                            beat_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr_d;
                        end
                    end else if (abort_d) begin
                        err_q    <= 1'b1;
                        err_id_q <= grant_q;
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr_d;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q == GRANT);
    assign bus.err      = err_q;
    assign bus.err_id   = err_id_q;

endmodule
